div_ctrl: RTL

Sequencing controller between the EX stage and the multi-cycle `div` unit in the MIPS core. It accepts DIV/DIVU from EX, latches the operands, drives the divider start/cancel handshake, and stalls the pipeline until the quotient and remainder are ready. It aborts the operation on pipeline flush and issues a one-cycle HI/LO write-back pulse.

---
 rtl/div_ctrl_pkg.sv | 29 ++
 rtl/div_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared widths, state encodings and payload types for the divider controller and the div unit.
package div_ctrl_pkg;

  localparam int unsigned REG_DATA_WIDTH    = 32;
  localparam int unsigned DOUBLE_DATA_WIDTH = 2 * REG_DATA_WIDTH;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    DIVC_IDLE   = 2'b00,
    DIVC_BUSY   = 2'b01,
    DIVC_DONE   = 2'b10,
    DIVC_CANCEL = 2'b11
  } divc_state_e;

  // Divider unit states, kept here so both blocks share one view.
  typedef enum logic [1:0] {
    DIV_FREE = 2'b00,
    DIV_ON   = 2'b01,
    DIV_ZERO = 2'b10,
    DIV_END  = 2'b11
  } div_state_e;

  // Divider result as delivered: remainder in the upper half, quotient in the lower.
  typedef struct packed {
    logic [REG_DATA_WIDTH-1:0] hi;
    logic [REG_DATA_WIDTH-1:0] lo;
  } hilo_t;

endpackage

// File: rtl/div_ctrl.sv
// EX-stage sequencer for the multi-cycle divider: operand latch, start/cancel handshake, stall, HI/LO write.
// Optional zero-operand bypass of the divider is enabled with `define DIV_FASTPATH_EN.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_div_valid,
  input  logic                ex_div_signed,
  input  logic [DATA_W-1:0]   ex_op1,
  input  logic [DATA_W-1:0]   ex_op2,
  input  logic                flush_in,
  output logic                stall_out,
  output logic                div_start_out,
  output logic                div_cancel_out,
  output logic                div_signed_out,
  output logic [DATA_W-1:0]   div_dived_out,
  output logic [DATA_W-1:0]   div_div_out,
  input  logic [2*DATA_W-1:0] div_res_in,
  input  logic                div_ready_in,
  output logic                hilo_we_out,
  output logic [DATA_W-1:0]   hi_out,
  output logic [DATA_W-1:0]   lo_out
);

  divc_state_e       state_q, state_d;
  logic              cnt_q, cnt_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic              sign_q, sign_d;
  hilo_t             hilo_q, hilo_d;
  logic              hilo_we_q, hilo_we_d;
  logic              start_q, start_d;
  logic              cancel_q, cancel_d;
  logic              stall_c;

  // Next-state, operand hold and write-back decisions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    sign_d    = sign_q;
    hilo_d    = hilo_q;
    hilo_we_d = 1'b0;
    stall_c   = 1'b0;

    unique case (state_q)
      DIVC_IDLE: begin
        if (ex_div_valid && !flush_in) begin
          stall_c = 1'b1;
          op1_d   = ex_op1;
          op2_d   = ex_op2;
          sign_d  = ex_div_signed;
          state_d = DIVC_BUSY;
`ifdef DIV_FASTPATH_EN
          if ((ex_op1 == '0) || (ex_op2 == '0)) begin
            hilo_d    = '0;
            hilo_we_d = 1'b1;
            state_d   = DIVC_DONE;
          end
`endif
        end
      end
      DIVC_BUSY: begin
        stall_c = 1'b1;
        // Flush takes priority so a result arriving with it is dropped.
        if (flush_in) begin
          cnt_d   = 1'b0;
          state_d = DIVC_CANCEL;
        end else if (div_ready_in) begin
          stall_c   = 1'b0;
          hilo_d    = hilo_t'(div_res_in);
          hilo_we_d = 1'b1;
          state_d   = DIVC_DONE;
        end
      end
      DIVC_DONE: begin
        stall_c = ex_div_valid;
        state_d = DIVC_IDLE;
      end
      DIVC_CANCEL: begin
        cnt_d = 1'b1;
        if (cnt_q) begin
          cnt_d   = 1'b0;
          op1_d   = '0;
          op2_d   = '0;
          sign_d  = 1'b0;
          state_d = DIVC_IDLE;
        end
      end
      default: state_d = DIVC_IDLE;
    endcase

    start_d  = (state_d == DIVC_BUSY);
    cancel_d = (state_d == DIVC_CANCEL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DIVC_IDLE;
      cnt_q     <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      sign_q    <= 1'b0;
      hilo_q    <= '0;
      hilo_we_q <= 1'b0;
      start_q   <= 1'b0;
      cancel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      sign_q    <= sign_d;
      hilo_q    <= hilo_d;
      hilo_we_q <= hilo_we_d;
      start_q   <= start_d;
      cancel_q  <= cancel_d;
    end
  end

  assign stall_out      = stall_c;
  assign div_start_out  = start_q;
  assign div_cancel_out = cancel_q;
  assign div_signed_out = sign_q;
  assign div_dived_out  = op1_q;
  assign div_div_out    = op2_q;
  assign hilo_we_out    = hilo_we_q;
  assign hi_out         = hilo_q.hi;
  assign lo_out         = hilo_q.lo;

endmodule
